// File: rtl/hacd_pkg.sv
// Shared types for the Hawk page-read sequencer: entry status, FSM state codes,
// table entry field positions, engine slot numbers and the table address helper.
package hacd_pkg;

  typedef enum logic [1:0] {
    STS_DALLOC = 2'd0,
    STS_UNCOMP = 2'd1,
    STS_COMP   = 2'd2,
    STS_INCOMP = 2'd3
  } hacd_sts_e;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOOKUP     = 4'd1,
    ST_WAIT_ATT   = 4'd2,
    ST_DECODE     = 4'd3,
    ST_POP_FREE   = 4'd4,
    ST_WAIT_LST   = 4'd5,
    ST_ALLOC      = 4'd6,
    ST_TBL_UPD    = 4'd7,
    ST_TBL_DONE   = 4'd8,
    ST_COMPRESS   = 4'd9,
    ST_DECOMPRESS = 4'd10,
    ST_COMPACT    = 4'd11,
    ST_BUS_ERROR  = 4'd12
  } pgrd_state_e;

  localparam int unsigned ENT_STS_W  = 2;
  localparam int unsigned ENT_PG_LSB = 12;
  localparam int unsigned PAGE_SHIFT = 12;

  localparam logic [1:0] SLOT_COMP    = 2'd0;
  localparam logic [1:0] SLOT_DECOMP  = 2'd1;
  localparam logic [1:0] SLOT_COMPACT = 2'd2;

  // Tables hold 8-byte entries, so an index maps to base + idx*8.
  function automatic logic [63:0] entry_addr(input logic [63:0] base, input logic [63:0] idx);
    return base + (idx << 3);
  endfunction

endpackage

// File: rtl/hawk_pgrd_rdmux.sv
// Shared AXI read-master mux: registers either the sequencer's own request or the
// active engine's slot onto the ports; rdm_reset follows the engine combinationally.
module hawk_pgrd_rdmux #(
  parameter int unsigned       ADDR_W   = 40,
  parameter logic [ADDR_W-1:0] ATT_BASE = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       eng_act_i,
  input  logic [1:0]                 eng_sel_i,
  input  logic [ADDR_W-1:0]          int_araddr_i,
  input  logic                       int_arvalid_i,
  input  logic [3*(ADDR_W+10)-1:0]   eng_rd_req_i,
  input  logic [2:0]                 eng_rdm_reset_i,
  output logic [ADDR_W-1:0]          araddr_o,
  output logic [7:0]                 arlen_o,
  output logic                       arvalid_o,
  output logic                       rready_o,
  output logic                       rdm_reset_o
);

  localparam int unsigned REQ_W = ADDR_W + 10;

  logic [REQ_W-1:0]  slot_req;
  logic              slot_rst;
  logic [ADDR_W-1:0] araddr_d;
  logic [7:0]        arlen_d;
  logic              arvalid_d, rready_d;

  always_comb begin
    case (eng_sel_i)
      2'd1:    begin slot_req = eng_rd_req_i[REQ_W +: REQ_W];   slot_rst = eng_rdm_reset_i[1]; end
      2'd2:    begin slot_req = eng_rd_req_i[2*REQ_W +: REQ_W]; slot_rst = eng_rdm_reset_i[2]; end
      default: begin slot_req = eng_rd_req_i[0 +: REQ_W];       slot_rst = eng_rdm_reset_i[0]; end
    endcase
  end

  always_comb begin
    if (eng_act_i) begin
      araddr_d  = slot_req[REQ_W-1 -: ADDR_W];
      arlen_d   = slot_req[9:2];
      arvalid_d = slot_req[1];
      rready_d  = slot_req[0];
    end else begin
      araddr_d  = int_araddr_i;
      arlen_d   = '0;
      arvalid_d = int_arvalid_i;
      rready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      araddr_o  <= ATT_BASE;
      arlen_o   <= '0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
    end else begin
      araddr_o  <= araddr_d;
      arlen_o   <= arlen_d;
      arvalid_o <= arvalid_d;
      rready_o  <= rready_d;
    end
  end

  assign rdm_reset_o = eng_act_i & slot_rst;

endmodule

// File: rtl/hawk_pgrd_seq.sv
// Hawk page-read sequencer: ATT lookup, free-list allocation and engine hand-off.
// Define HAWK_COMPACT_EN to enable the compaction path (compact_req / COMPACT state).
module hawk_pgrd_seq
  import hacd_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 40,
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       IDX_W     = 16,
  parameter logic [ADDR_W-1:0] HPPA_BASE = 40'h80_0000_0000,
  parameter logic [ADDR_W-1:0] ATT_BASE  = '0,
  parameter logic [ADDR_W-1:0] TOL_BASE  = 40'h1000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     lookup,
  input  logic [ADDR_W-13:0]       lookup_hppa,
  input  logic [IDX_W-1:0]         free_head,
  input  logic [IDX_W-1:0]         uncomp_head,
  input  logic [IDX_W-1:0]         uncomp_tail,
  input  logic                     arready,
  input  logic                     rvalid,
  input  logic                     rlast,
  input  logic [1:0]               rresp,
  input  logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic                     arvalid,
  output logic                     rready,
  output logic                     allow_access,
  output logic                     trnsl_nack,
  output logic [ADDR_W-1:0]        trnsl_ppa,
  output logic [1:0]               trnsl_sts,
  input  logic                     pgwr_mngr_ready,
  input  logic                     tbl_update_done,
  output logic                     tbl_update,
  output logic [ADDR_W-13:0]       tol_att_id,
  output logic [ADDR_W-13:0]       tol_way,
  output logic [IDX_W-1:0]         tol_lst_idx,
  output logic                     comp_trig,
  output logic                     decomp_trig,
  output logic                     compact_trig,
  input  logic                     comp_done,
  input  logic                     decomp_done,
  input  logic                     compact_done,
  input  logic                     compact_req,
  input  logic [ADDR_W-13:0]       comp_freeway,
  output logic [ADDR_W-1:0]        decomp_freeway,
  output logic [ADDR_W-1:0]        decomp_cpage,
  input  logic [3*(ADDR_W+10)-1:0] eng_rd_req,
  input  logic [2:0]               eng_rdm_reset,
  output logic                     rdm_reset,
  output logic                     pgrd_mngr_ready,
  output logic                     bus_error
);

  localparam int unsigned PG_W = ADDR_W - PAGE_SHIFT;

  pgrd_state_e       state_q, state_d;
  hacd_sts_e         ent_sts_q, ent_sts_d;
  logic [PG_W-1:0]   att_id_q, att_id_d, ent_pg_q, ent_pg_d;
  logic [PG_W-1:0]   tol_att_q, tol_att_d, tol_way_q, tol_way_d;
  logic [IDX_W-1:0]  tol_idx_q, tol_idx_d;
  logic [ADDR_W-1:0] int_araddr_q, int_araddr_d, ppa_q, ppa_d;
  logic [ADDR_W-1:0] dfree_q, dfree_d, dcpage_q, dcpage_d;
  logic [1:0]        sts_q, sts_d;
  logic              from_free_q, from_free_d, allow_q, allow_d, nack_q, nack_d;
  logic              tbl_upd_q, tbl_upd_d, int_arvalid, rd_ok, eng_act;
  logic [1:0]        eng_sel;

  assign rd_ok = rvalid && rlast;

  always_comb begin
    state_d      = state_q;
    ent_sts_d    = ent_sts_q;
    att_id_d     = att_id_q;
    ent_pg_d     = ent_pg_q;
    tol_att_d    = tol_att_q;
    tol_way_d    = tol_way_q;
    tol_idx_d    = tol_idx_q;
    int_araddr_d = int_araddr_q;
    ppa_d        = ppa_q;
    sts_d        = sts_q;
    dfree_d      = dfree_q;
    dcpage_d     = dcpage_q;
    from_free_d  = from_free_q;
    allow_d      = 1'b0;
    nack_d       = 1'b0;
    tbl_upd_d    = 1'b0;
    int_arvalid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The requester still holds lookup during the completion pulse; don't re-accept it.
        if (lookup && !allow_q && !nack_q) begin
          att_id_d    = lookup_hppa - HPPA_BASE[ADDR_W-1:PAGE_SHIFT] + PG_W'(1);
          from_free_d = 1'b0;
          state_d     = ST_LOOKUP;
        end
`ifdef HAWK_COMPACT_EN
        else if (compact_req) state_d = ST_COMPACT;
`endif
      end
      ST_LOOKUP: if (arready && !arvalid) begin
        int_araddr_d = ADDR_W'(entry_addr(64'(ATT_BASE), 64'(att_id_q)));
        int_arvalid  = 1'b1;
        state_d      = ST_WAIT_ATT;
      end
      ST_WAIT_ATT: if (rd_ok) begin
        if (rresp == 2'b00) begin
          ent_sts_d = hacd_sts_e'(rdata[ENT_STS_W-1:0]);
          ent_pg_d  = rdata[ENT_PG_LSB +: PG_W];
          state_d   = ST_DECODE;
        end else begin
          state_d = ST_BUS_ERROR;
        end
      end
      ST_DECODE: begin
        if (ent_sts_q == STS_UNCOMP || ent_sts_q == STS_INCOMP) begin
          allow_d = 1'b1;
          ppa_d   = {ent_pg_q, {PAGE_SHIFT{1'b0}}};
          sts_d   = ent_sts_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_POP_FREE;
        end
      end
      ST_POP_FREE: begin
        if (free_head != '0) begin
          int_araddr_d = ADDR_W'(entry_addr(64'(TOL_BASE), 64'(free_head)));
          int_arvalid  = 1'b1;
          state_d      = ST_WAIT_LST;
        end else if (uncomp_head != uncomp_tail) begin
          state_d = ST_COMPRESS;
        end else begin
          nack_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LST: if (rd_ok) begin
        tol_att_d   = att_id_q;
        tol_way_d   = rdata[ENT_PG_LSB +: PG_W];
        tol_idx_d   = free_head;
        from_free_d = 1'b1;
        if (ent_sts_q == STS_COMP) begin
          dfree_d  = {rdata[ENT_PG_LSB +: PG_W], {PAGE_SHIFT{1'b0}}};
          dcpage_d = {ent_pg_q, {PAGE_SHIFT{1'b0}}};
          state_d  = ST_DECOMPRESS;
        end else begin
          state_d = ST_ALLOC;
        end
      end
      ST_ALLOC: begin
        ppa_d   = {tol_way_q, {PAGE_SHIFT{1'b0}}};
        sts_d   = STS_UNCOMP;
        state_d = ST_TBL_UPD;
      end
      ST_TBL_UPD: if (pgwr_mngr_ready) begin
        tbl_upd_d = 1'b1;
        state_d   = ST_TBL_DONE;
      end
      ST_TBL_DONE: if (tbl_update_done) begin
        allow_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_COMPRESS: if (comp_done) begin
        if (ent_sts_q == STS_COMP) begin
          dfree_d  = {comp_freeway, {PAGE_SHIFT{1'b0}}};
          dcpage_d = {ent_pg_q, {PAGE_SHIFT{1'b0}}};
          state_d  = ST_DECOMPRESS;
        end else begin
          allow_d = 1'b1;
          ppa_d   = {comp_freeway, {PAGE_SHIFT{1'b0}}};
          sts_d   = STS_UNCOMP;
          state_d = ST_IDLE;
        end
      end
      ST_DECOMPRESS: if (decomp_done) begin
        ppa_d = dfree_q;
        sts_d = STS_UNCOMP;
        if (from_free_q) begin
          state_d = ST_TBL_UPD;
        end else begin
          allow_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_COMPACT:   if (compact_done) state_d = ST_IDLE;
      ST_BUS_ERROR: state_d = ST_BUS_ERROR;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      ent_sts_q    <= STS_DALLOC;
      att_id_q     <= '0;
      ent_pg_q     <= '0;
      tol_att_q    <= '0;
      tol_way_q    <= '0;
      tol_idx_q    <= '0;
      int_araddr_q <= ATT_BASE;
      ppa_q        <= '0;
      sts_q        <= '0;
      dfree_q      <= '0;
      dcpage_q     <= '0;
      from_free_q  <= 1'b0;
      allow_q      <= 1'b0;
      nack_q       <= 1'b0;
      tbl_upd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ent_sts_q    <= ent_sts_d;
      att_id_q     <= att_id_d;
      ent_pg_q     <= ent_pg_d;
      tol_att_q    <= tol_att_d;
      tol_way_q    <= tol_way_d;
      tol_idx_q    <= tol_idx_d;
      int_araddr_q <= int_araddr_d;
      ppa_q        <= ppa_d;
      sts_q        <= sts_d;
      dfree_q      <= dfree_d;
      dcpage_q     <= dcpage_d;
      from_free_q  <= from_free_d;
      allow_q      <= allow_d;
      nack_q       <= nack_d;
      tbl_upd_q    <= tbl_upd_d;
    end
  end

  always_comb begin
    eng_act = 1'b1;
    eng_sel = SLOT_COMP;
    case (state_q)
      ST_COMPRESS:   eng_sel = SLOT_COMP;
      ST_DECOMPRESS: eng_sel = SLOT_DECOMP;
      ST_COMPACT:    eng_sel = SLOT_COMPACT;
      default:       eng_act = 1'b0;
    endcase
  end

  hawk_pgrd_rdmux #(
    .ADDR_W   (ADDR_W),
    .ATT_BASE (ATT_BASE)
  ) u_rdmux (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .eng_act_i       (eng_act),
    .eng_sel_i       (eng_sel),
    .int_araddr_i    (int_araddr_d),
    .int_arvalid_i   (int_arvalid),
    .eng_rd_req_i    (eng_rd_req),
    .eng_rdm_reset_i (eng_rdm_reset),
    .araddr_o        (araddr),
    .arlen_o         (arlen),
    .arvalid_o       (arvalid),
    .rready_o        (rready),
    .rdm_reset_o     (rdm_reset)
  );

  assign comp_trig       = (state_q == ST_COMPRESS);
  assign decomp_trig     = (state_q == ST_DECOMPRESS);
`ifdef HAWK_COMPACT_EN
  assign compact_trig    = (state_q == ST_COMPACT);
`else
  assign compact_trig    = 1'b0;
  logic unused_compact;
  assign unused_compact  = compact_req;
`endif
  assign pgrd_mngr_ready = (state_q == ST_IDLE);
  assign bus_error       = (state_q == ST_BUS_ERROR);

  assign allow_access    = allow_q;
  assign trnsl_nack      = nack_q;
  assign trnsl_ppa       = ppa_q;
  assign trnsl_sts       = sts_q;
  assign tbl_update      = tbl_upd_q;
  assign tol_att_id      = tol_att_q;
  assign tol_way         = tol_way_q;
  assign tol_lst_idx     = tol_idx_q;
  assign decomp_freeway  = dfree_q;
  assign decomp_cpage    = dcpage_q;

  logic unused_rdata;
  assign unused_rdata = ^{rdata[DATA_W-1:ENT_PG_LSB+PG_W], rdata[ENT_PG_LSB-1:ENT_STS_W]};

endmodule

// File: tb/tb_hawk_pgrd_seq.sv
// Scoreboard bench for hawk_pgrd_seq: expected completions are queued per lookup
// and checked when allow_access / trnsl_nack fires; AXI slave and engines are modelled inline.
module tb_hawk_pgrd_seq;

  localparam int unsigned ADDR_W = 40;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned PG_W   = 28;
  localparam int unsigned REQ_W  = 50;
  localparam logic [PG_W-1:0] HPN = 28'h800_0000;

  logic                 clk_i = 1'b0, rst_ni = 1'b0;
  logic                 lookup = 1'b0;
  logic [PG_W-1:0]      lookup_hppa = '0;
  logic [IDX_W-1:0]     free_head = '0, uncomp_head = '0, uncomp_tail = '0;
  logic                 arready = 1'b1, rvalid = 1'b0, rlast = 1'b0;
  logic [1:0]           rresp = '0;
  logic [DATA_W-1:0]    rdata = '0;
  logic [ADDR_W-1:0]    araddr;
  logic [7:0]           arlen;
  logic                 arvalid, rready, allow_access, trnsl_nack;
  logic [ADDR_W-1:0]    trnsl_ppa;
  logic [1:0]           trnsl_sts;
  logic                 pgwr_mngr_ready = 1'b0, tbl_update_done = 1'b0, tbl_update;
  logic [PG_W-1:0]      tol_att_id, tol_way;
  logic [IDX_W-1:0]     tol_lst_idx;
  logic                 comp_trig, decomp_trig, compact_trig;
  logic                 comp_done = 1'b0, decomp_done = 1'b0, compact_done = 1'b0, compact_req = 1'b0;
  logic [PG_W-1:0]      comp_freeway = '0;
  logic [ADDR_W-1:0]    decomp_freeway, decomp_cpage;
  logic [3*REQ_W-1:0]   eng_rd_req = '0;
  logic [2:0]           eng_rdm_reset = '0;
  logic                 rdm_reset, pgrd_mngr_ready, bus_error;

  hawk_pgrd_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lookup(lookup), .lookup_hppa(lookup_hppa),
    .free_head(free_head), .uncomp_head(uncomp_head), .uncomp_tail(uncomp_tail),
    .arready(arready), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rdata(rdata),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .rready(rready),
    .allow_access(allow_access), .trnsl_nack(trnsl_nack), .trnsl_ppa(trnsl_ppa), .trnsl_sts(trnsl_sts),
    .pgwr_mngr_ready(pgwr_mngr_ready), .tbl_update_done(tbl_update_done), .tbl_update(tbl_update),
    .tol_att_id(tol_att_id), .tol_way(tol_way), .tol_lst_idx(tol_lst_idx),
    .comp_trig(comp_trig), .decomp_trig(decomp_trig), .compact_trig(compact_trig),
    .comp_done(comp_done), .decomp_done(decomp_done), .compact_done(compact_done), .compact_req(compact_req),
    .comp_freeway(comp_freeway), .decomp_freeway(decomp_freeway), .decomp_cpage(decomp_cpage),
    .eng_rd_req(eng_rd_req), .eng_rdm_reset(eng_rdm_reset), .rdm_reset(rdm_reset),
    .pgrd_mngr_ready(pgrd_mngr_ready), .bus_error(bus_error)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic              nack;
    logic [ADDR_W-1:0] ppa;
    logic [1:0]        sts;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0, n_err = 0, n_tbl = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (tbl_update) n_tbl++;
      if (allow_access || trnsl_nack) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 64'(allow_access | trnsl_nack), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_nack", 64'(trnsl_nack), 64'(e.nack));
          chk("sb_access", 64'(allow_access), 64'(!e.nack));
          if (!e.nack) begin
            chk("sb_ppa", 64'(trnsl_ppa), 64'(e.ppa));
            chk("sb_sts", 64'(trnsl_sts), 64'(e.sts));
          end
        end
      end
    end
  end

  function automatic logic [63:0] ent(input logic [PG_W-1:0] pg, input logic [1:0] s);
    return {24'h0, pg, 10'h0, s};
  endfunction

  function automatic exp_t hit(input logic [ADDR_W-1:0] ppa, input logic [1:0] s);
    exp_t e;
    e.nack = 1'b0; e.ppa = ppa; e.sts = s;
    return e;
  endfunction

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_ar(input string tag, input logic [ADDR_W-1:0] a);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (arvalid) seen = 1'b1; else step();
    end
    chk({tag, "_ar_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_araddr"}, 64'(araddr), 64'(a));
      chk({tag, "_arlen"}, 64'(arlen), 64'd0);
    end
  endtask

  task automatic rsp(input logic [63:0] d, input logic [1:0] r);
    rvalid = 1'b1; rlast = 1'b1; rdata = d; rresp = r;
    step();
    rvalid = 1'b0; rlast = 1'b0; rresp = '0;
  endtask

  // sel: 0 tbl_update, 1 comp_trig, 2 decomp_trig, 3 compact_trig, 4 completion pulse
  task automatic wait_for(input string tag, input int sel);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      case (sel)
        0: seen = tbl_update;
        1: seen = comp_trig;
        2: seen = decomp_trig;
        3: seen = compact_trig;
        default: seen = allow_access | trnsl_nack;
      endcase
      if (!seen) step();
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic tbl_handshake(input string tag);
    pgwr_mngr_ready = 1'b1;
    wait_for({tag, "_tblupd"}, 0);
    pgwr_mngr_ready = 1'b0;
    tbl_update_done = 1'b1;
    step();
    tbl_update_done = 1'b0;
  endtask

  initial begin
    // reset
    step(); step();
    chk("rst_araddr", 64'(araddr), 64'h0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_allow", 64'(allow_access), 64'd0);
    chk("rst_ppa", 64'(trnsl_ppa), 64'd0);
    chk("rst_pgrd_ready", 64'(pgrd_mngr_ready), 64'd1);
    chk("rst_bus_error", 64'(bus_error), 64'd0);
    rst_ni = 1'b1;
    step();
    chk("idle_rready", 64'(rready), 64'd1);

    // UNCOMP hit
    sb_q.push_back(hit(40'h123_4000, 2'd1));
    lookup = 1'b1; lookup_hppa = HPN + 28'd3;
    wait_ar("t1", 40'h20);
    rsp(ent(28'h1234, 2'd1), 2'b00);
    wait_for("t1_done", 4);
    lookup = 1'b0;
    chk("t1_no_tbl", 64'(n_tbl), 64'd0);

    // DALLOC with allocation from the free list
    free_head = 16'd5;
    sb_q.push_back(hit(40'h7_7000, 2'd1));
    lookup = 1'b1; lookup_hppa = HPN + 28'd7;
    wait_ar("t2_att", 40'h40);
    rsp(ent(28'h0, 2'd0), 2'b00);
    wait_ar("t2_tol", 40'h1000_0028);
    rsp(ent(28'h77, 2'd0), 2'b00);
    step(); step(); step();
    chk("t2_wait_pgwr", 64'(n_tbl), 64'd0);
    chk("t2_tol_way", 64'(tol_way), 64'h77);
    chk("t2_tol_idx", 64'(tol_lst_idx), 64'd5);
    chk("t2_tol_att", 64'(tol_att_id), 64'd8);
    tbl_handshake("t2");
    wait_for("t2_done", 4);
    lookup = 1'b0;
    chk("t2_tbl_cnt", 64'(n_tbl), 64'd1);

    // COMP with a free way: decompress then table update
    free_head = 16'd2;
    sb_q.push_back(hit(40'h5_5000, 2'd1));
    lookup = 1'b1; lookup_hppa = HPN + 28'd9;
    wait_ar("t3_att", 40'h50);
    rsp(ent(28'hABCD, 2'd2), 2'b00);
    wait_ar("t3_tol", 40'h1000_0010);
    rsp(ent(28'h55, 2'd0), 2'b00);
    wait_for("t3_dtrig", 2);
    chk("t3_cpage", 64'(decomp_cpage), 64'hABCD000);
    chk("t3_freeway", 64'(decomp_freeway), 64'h55000);
    eng_rd_req[REQ_W +: REQ_W] = {40'h12_3456_7800, 8'd3, 1'b1, 1'b1};
    eng_rdm_reset = 3'b010;
    #1;
    chk("t3_rdm_reset", 64'(rdm_reset), 64'd1);
    step();
    chk("t3_eng_araddr", 64'(araddr), 64'h12_3456_7800);
    chk("t3_eng_arlen", 64'(arlen), 64'd3);
    chk("t3_eng_arvalid", 64'(arvalid), 64'd1);
    eng_rd_req = '0; eng_rdm_reset = '0;
    decomp_done = 1'b1;
    step();
    decomp_done = 1'b0;
    tbl_handshake("t3");
    wait_for("t3_done", 4);
    lookup = 1'b0;
    chk("t3_tbl_cnt", 64'(n_tbl), 64'd2);

    // No free way, uncompressed list non-empty: compress path
    free_head = '0; uncomp_head = 16'd3; uncomp_tail = 16'd4;
    sb_q.push_back(hit(40'h9000, 2'd1));
    lookup = 1'b1; lookup_hppa = HPN + 28'd1;
    wait_ar("t4", 40'h10);
    rsp(ent(28'h5, 2'd0), 2'b00);
    wait_for("t4_ctrig", 1);
    eng_rdm_reset = 3'b111;
    comp_freeway = 28'h9; comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    wait_for("t4_done", 4);
    lookup = 1'b0;
    chk("t4_idle_rdm_reset", 64'(rdm_reset), 64'd0);
    eng_rdm_reset = '0;

    // Nothing to allocate or compress: nack
    uncomp_tail = 16'd3;
    sb_q.push_back('{nack: 1'b1, ppa: '0, sts: '0});
    lookup = 1'b1; lookup_hppa = HPN + 28'd2;
    wait_ar("t5", 40'h18);
    rsp(ent(28'h6, 2'd0), 2'b00);
    wait_for("t5_done", 4);
    lookup = 1'b0;
    chk("t5_no_tbl", 64'(n_tbl), 64'd2);

    // COMP entry without free way: compress, then decompress into the freed way
    uncomp_tail = 16'd4;
    sb_q.push_back(hit(40'h9000, 2'd1));
    lookup = 1'b1; lookup_hppa = HPN + 28'd4;
    wait_ar("t6", 40'h28);
    rsp(ent(28'h42, 2'd2), 2'b00);
    wait_for("t6_ctrig", 1);
    comp_freeway = 28'h9; comp_done = 1'b1;
    step();
    comp_done = 1'b0;
    wait_for("t6_dtrig", 2);
    chk("t6_freeway", 64'(decomp_freeway), 64'h9000);
    chk("t6_cpage", 64'(decomp_cpage), 64'h42000);
    decomp_done = 1'b1;
    step();
    decomp_done = 1'b0;
    wait_for("t6_done", 4);
    lookup = 1'b0;
    chk("t6_no_tbl", 64'(n_tbl), 64'd2);

    // att_id wraps to 0; INCOMP hit with the largest page number
    sb_q.push_back(hit(40'hFF_FFFF_F000, 2'd3));
    lookup = 1'b1; lookup_hppa = HPN - 28'd1;
    wait_ar("t7", 40'h0);
    rsp(ent(28'hFFF_FFFF, 2'd3), 2'b00);
    wait_for("t7_done", 4);
    lookup = 1'b0;
    step();

`ifdef HAWK_COMPACT_EN
    compact_req = 1'b1;
    step();
    compact_req = 1'b0;
    chk("t8_compact_trig", 64'(compact_trig), 64'd1);
    eng_rd_req[2*REQ_W +: REQ_W] = {40'h0C_0DE0_0000, 8'd0, 1'b1, 1'b1};
    step();
    chk("t8_eng_araddr", 64'(araddr), 64'h0C_0DE0_0000);
    eng_rd_req = '0;
    compact_done = 1'b1;
    step();
    compact_done = 1'b0;
    chk("t8_back_idle", 64'(pgrd_mngr_ready), 64'd1);
`else
    compact_req = 1'b1;
    step(); step();
    chk("t8_compact_trig", 64'(compact_trig), 64'd0);
    chk("t8_stay_idle", 64'(pgrd_mngr_ready), 64'd1);
    compact_req = 1'b0;
`endif

    // Bus error on the ATT read is sticky until reset
    lookup = 1'b1; lookup_hppa = HPN + 28'd3;
    wait_ar("t9", 40'h20);
    rsp(ent(28'h1, 2'd1), 2'b10);
    chk("t9_bus_error", 64'(bus_error), 64'd1);
    chk("t9_not_ready", 64'(pgrd_mngr_ready), 64'd0);
    begin
      int unsigned n_ar = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (arvalid) n_ar++;
      end
      chk("t9_no_ar", 64'(n_ar), 64'd0);
    end
    chk("t9_sticky", 64'(bus_error), 64'd1);
    rst_ni = 1'b0;
    step();
    chk("t9_rst_bus_error", 64'(bus_error), 64'd0);
    chk("t9_rst_ready", 64'(pgrd_mngr_ready), 64'd1);
    rst_ni = 1'b1; lookup = 1'b0;
    step();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
